lsu_subword_ctrl: RTL and testbench

- Load/store unit between the MEM pipeline stage and the word-wide data memory. The memory has no byte enables, a registered one-cycle read, and word indexing (index 0..255).
- Converts byte addresses to word indices.
- Sign- or zero-extends byte and halfword loads.
- Performs SB/SH as read-modify-write.
- Flags misaligned and out-of-range accesses without touching memory.

---
 rtl/lsu_subword_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_lsu_subword_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_subword_ctrl.sv
// Load/store unit between the MEM stage and a word-wide, byte-enable-less data memory.
// Handles sub-word loads (with extension), SB/SH via read-modify-write, and error screening.
module lsu_subword_ctrl #(
  parameter int ADDR_WORDS_LOG2 = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] rdata_o,
  output logic        mem_MemRead_o,
  output logic        mem_MemWrite_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_WriteData_o,
  input  logic [31:0] mem_ReadData_i
);

  // Byte-address bits that can legally be non-zero.
  localparam int AW = ADDR_WORDS_LOG2 + 2;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LH  = 3'd1,
    OP_LW  = 3'd2,
    OP_LBU = 3'd3,
    OP_LHU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  op_e           op_in, op_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merged_q;
  logic [31:0]   rdata_q;
  logic          resp_err_q;

  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic          accept;
  logic          is_load;
  logic [31:0]   word_idx;

  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic [31:0]   merged_d;

  assign op_in    = op_e'(op_i);
  assign accept   = (state_q == S_IDLE) && req_valid_i;
  assign is_load  = op_q inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  assign word_idx = {{(34 - AW){1'b0}}, addr_q[AW-1:2]};

  // Request screening is done on the live inputs so errors skip memory entirely.
  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    misaligned = 1'b0;
    case (op_in)
      OP_LH, OP_LHU, OP_SH: misaligned = addr_i[0];
      OP_LW, OP_SW:         misaligned = (addr_i[1:0] != 2'b00);
      default:              misaligned = 1'b0;
    endcase
  end

  assign out_of_range = |(addr_i >> AW);
  assign req_err      = misaligned || out_of_range;

  // Lane extraction and merge operate on the word returned for the latched address.
  always_comb begin
    rd_byte = mem_ReadData_i[7:0];
    case (addr_q[1:0])
      2'd0: rd_byte = mem_ReadData_i[7:0];
      2'd1: rd_byte = mem_ReadData_i[15:8];
      2'd2: rd_byte = mem_ReadData_i[23:16];
      2'd3: rd_byte = mem_ReadData_i[31:24];
      default: rd_byte = mem_ReadData_i[7:0];
    endcase
    rd_half = addr_q[1] ? mem_ReadData_i[31:16] : mem_ReadData_i[15:0];
  end

  always_comb begin
    load_val = 32'd0;
    case (op_q)
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LH:   load_val = {{16{rd_half[15]}}, rd_half};
      OP_LW:   load_val = mem_ReadData_i;
      OP_LBU:  load_val = {24'd0, rd_byte};
      OP_LHU:  load_val = {16'd0, rd_half};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    merged_d = mem_ReadData_i;
    if (op_q == OP_SB) begin
      case (addr_q[1:0])
        2'd0: merged_d[7:0]   = wdata_q[7:0];
        2'd1: merged_d[15:8]  = wdata_q[7:0];
        2'd2: merged_d[23:16] = wdata_q[7:0];
        2'd3: merged_d[31:24] = wdata_q[7:0];
        default: merged_d = mem_ReadData_i;
      endcase
    end else if (op_q == OP_SH) begin
      if (addr_q[1]) merged_d[31:16] = wdata_q[15:0];
      else           merged_d[15:0]  = wdata_q[15:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_err)              state_d = S_RESP;
          else if (op_in == OP_SW)  state_d = S_WRITE;
          else                      state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = is_load ? S_RESP : S_WRITE;
      S_WRITE: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and bus values come only from registered state; the bus idles at zero.
  always_comb begin
    req_ready_o     = 1'b0;
    resp_valid_o    = 1'b0;
    mem_MemRead_o   = 1'b0;
    mem_MemWrite_o  = 1'b0;
    mem_addr_o      = 32'd0;
    mem_WriteData_o = 32'd0;
    case (state_q)
      S_IDLE: req_ready_o = 1'b1;
      S_READ: begin
        mem_MemRead_o = 1'b1;
        mem_addr_o    = word_idx;
      end
      S_WRITE: begin
        mem_MemWrite_o  = 1'b1;
        mem_addr_o      = word_idx;
        mem_WriteData_o = (op_q == OP_SW) ? wdata_q : merged_q;
      end
      S_RESP: resp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request latches and response fields; response fields only move on entry to RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q       <= OP_LB;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      merged_q   <= 32'd0;
      rdata_q    <= 32'd0;
      resp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        addr_q  <= addr_i[AW-1:0];
        wdata_q <= wdata_i;
        if (req_err) begin
          rdata_q    <= 32'd0;
          resp_err_q <= 1'b1;
        end
      end
      if (state_q == S_WAIT) begin
        if (is_load) begin
          rdata_q    <= load_val;
          resp_err_q <= 1'b0;
        end else begin
          merged_q <= merged_d;
        end
      end
      if (state_q == S_WRITE) begin
        rdata_q    <= 32'd0;
        resp_err_q <= 1'b0;
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign resp_err_o = resp_err_q;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Scoreboard bench for lsu_subword_ctrl with a registered-read word memory model.
module tb_lsu_subword_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        resp_valid_o;
  logic        resp_err_o;
  logic [31:0] rdata_o;
  logic        mem_MemRead_o;
  logic        mem_MemWrite_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_WriteData_o;
  logic [31:0] mem_ReadData_i;

  lsu_subword_ctrl #(.ADDR_WORDS_LOG2(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .op_i            (op_i),
    .addr_i          (addr_i),
    .wdata_i         (wdata_i),
    .resp_valid_o    (resp_valid_o),
    .resp_err_o      (resp_err_o),
    .rdata_o         (rdata_o),
    .mem_MemRead_o   (mem_MemRead_o),
    .mem_MemWrite_o  (mem_MemWrite_o),
    .mem_addr_o      (mem_addr_o),
    .mem_WriteData_o (mem_WriteData_o),
    .mem_ReadData_i  (mem_ReadData_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory: registered read, word write, plus a bench-only preload port.
  logic [31:0] mem [256];
  logic        tb_we;
  logic [7:0]  tb_wa;
  logic [31:0] tb_wd;

  always @(posedge clk_i) begin
    if (tb_we)               mem[tb_wa] <= tb_wd;
    else if (mem_MemWrite_o) mem[mem_addr_o[7:0]] <= mem_WriteData_o;
    if (mem_MemRead_o)       mem_ReadData_i <= mem[mem_addr_o[7:0]];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [7:0]  idx;
    logic [31:0] wd;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference behaviour; also commits successful stores to the shadow memory.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] w, sh, mask;
    logic [7:0]  b;
    logic [15:0] h;
    e.idx   = addr[9:2];
    e.rdata = 32'd0;
    e.wd    = 32'd0;
    e.nrd   = 0;
    e.nwr   = 0;
    e.lat   = 1;
    e.err   = (addr[31:10] != 22'd0) ||
              (((op == 3'd1) || (op == 3'd4) || (op == 3'd6)) && addr[0]) ||
              (((op == 3'd2) || (op == 3'd7)) && (addr[1:0] != 2'b00));
    if (!e.err) begin
      w  = ref_mem[e.idx];
      sh = w >> {addr[1:0], 3'b000};
      b  = sh[7:0];
      h  = addr[1] ? w[31:16] : w[15:0];
      case (op)
        3'd0: begin e.rdata = {{24{b[7]}}, b};  e.lat = 3; e.nrd = 1; end
        3'd1: begin e.rdata = {{16{h[15]}}, h}; e.lat = 3; e.nrd = 1; end
        3'd2: begin e.rdata = w;                e.lat = 3; e.nrd = 1; end
        3'd3: begin e.rdata = {24'd0, b};       e.lat = 3; e.nrd = 1; end
        3'd4: begin e.rdata = {16'd0, h};       e.lat = 3; e.nrd = 1; end
        3'd5: begin
          mask = 32'h0000_00FF << {addr[1:0], 3'b000};
          e.wd = (w & ~mask) | (({24'd0, wdata[7:0]} << {addr[1:0], 3'b000}) & mask);
          e.lat = 4; e.nrd = 1; e.nwr = 1;
        end
        3'd6: begin
          mask = 32'h0000_FFFF << {addr[1], 4'b0000};
          e.wd = (w & ~mask) | (({16'd0, wdata[15:0]} << {addr[1], 4'b0000}) & mask);
          e.lat = 4; e.nrd = 1; e.nwr = 1;
        end
        default: begin e.wd = wdata; e.lat = 2; e.nwr = 1; end
      endcase
      if (e.nwr == 1) ref_mem[e.idx] = e.wd;
    end
    return e;
  endfunction

  // One complete transaction; with hold=1 the request lines keep toggling while busy.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit hold);
    exp_t e, got;
    int   n, nrd, nwr;
    bit   seen, busy_ready, bad_bus;
    @(negedge clk_i);
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready op=%0d addr=%h: ready=%b resp_valid=%b, need 1/0",
               op, addr, req_ready_o, resp_valid_o);
    end
    req_valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wdata;
    e = model(op, addr, wdata);
    exp_q.push_back(e);
    @(posedge clk_i);
    n = 0; nrd = 0; nwr = 0; seen = 0; busy_ready = 0; bad_bus = 0;
    while (!seen && n < 12) begin
      @(negedge clk_i);
      n++;
      if (hold) begin
        op_i = 3'($urandom); addr_i = $urandom_range(0, 1023); wdata_i = $urandom;
      end else begin
        req_valid_i = 1'b0;
      end
      if (req_ready_o) busy_ready = 1;
      if (mem_MemRead_o) begin
        nrd++;
        if (mem_addr_o !== {24'd0, e.idx}) bad_bus = 1;
      end
      if (mem_MemWrite_o) begin
        nwr++;
        if (mem_addr_o !== {24'd0, e.idx} || mem_WriteData_o !== e.wd) bad_bus = 1;
      end
      if (!mem_MemRead_o && !mem_MemWrite_o && (mem_addr_o !== 32'd0 || mem_WriteData_o !== 32'd0))
        bad_bus = 1;
      if (resp_valid_o) seen = 1;
    end
    req_valid_i = 1'b0;
    got = exp_q.pop_front();
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL resp_timeout op=%0d addr=%h: no resp_valid within 12 cycles", op, addr);
    end
    vectors++;
    if (n !== got.lat) begin
      miscompares++;
      $display("FAIL latency op=%0d addr=%h: got %0d cycles, need %0d", op, addr, n, got.lat);
    end
    vectors++;
    if (resp_err_o !== got.err) begin
      miscompares++;
      $display("FAIL resp_err op=%0d addr=%h: got %b, need %b", op, addr, resp_err_o, got.err);
    end
    vectors++;
    if (rdata_o !== got.rdata) begin
      miscompares++;
      $display("FAIL rdata op=%0d addr=%h: got %h, need %h", op, addr, rdata_o, got.rdata);
    end
    vectors++;
    if (nrd !== got.nrd || nwr !== got.nwr) begin
      miscompares++;
      $display("FAIL strobes op=%0d addr=%h: reads=%0d writes=%0d, need %0d/%0d",
               op, addr, nrd, nwr, got.nrd, got.nwr);
    end
    vectors++;
    if (busy_ready || bad_bus) begin
      miscompares++;
      $display("FAIL bus op=%0d addr=%h: ready_while_busy=%b bad_bus=%b, need 0/0",
               op, addr, busy_ready, bad_bus);
    end
  endtask

  task automatic preload();
    logic [31:0] v;
    for (int i = 0; i < 256; i++) begin
      v = (i == 3) ? 32'h8899_AABB : (32'h0101_0101 * i) ^ 32'h5A3C_96E1;
      @(negedge clk_i);
      tb_we = 1'b1; tb_wa = 8'(i); tb_wd = v;
      ref_mem[i] = v;
    end
    @(negedge clk_i);
    tb_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_err_o !== 1'b0 || rdata_o !== 32'd0 ||
        mem_MemRead_o !== 1'b0 || mem_MemWrite_o !== 1'b0 || mem_addr_o !== 32'd0 ||
        mem_WriteData_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b rv=%b err=%b rdata=%h rd=%b wr=%b addr=%h wd=%h, need 1/0/0/0/0/0/0/0",
               req_ready_o, resp_valid_o, resp_err_o, rdata_o, mem_MemRead_o, mem_MemWrite_o,
               mem_addr_o, mem_WriteData_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_loads();
    issue(3'd0, 32'h0D, 32'h0, 0);   // LB  -> FFFFFFAA
    issue(3'd3, 32'h0D, 32'h0, 0);   // LBU -> 000000AA
    issue(3'd1, 32'h0E, 32'h0, 0);   // LH  -> FFFF8899
    issue(3'd4, 32'h0E, 32'h0, 0);   // LHU -> 00008899
    issue(3'd2, 32'h0C, 32'h0, 0);
    issue(3'd0, 32'h0C, 32'h0, 0);
    issue(3'd3, 32'h0F, 32'h0, 0);
    issue(3'd1, 32'h3FC, 32'h0, 0);
  endtask

  task automatic test_subword_store();
    issue(3'd5, 32'h0E, 32'h1234_5611, 0);  // word 3 -> 8811AABB
    issue(3'd2, 32'h0C, 32'h0, 0);
    issue(3'd6, 32'h12, 32'hFFFF_CAFE, 0);
    issue(3'd2, 32'h10, 32'h0, 0);
    issue(3'd5, 32'h23, 32'h0000_0080, 0);
    issue(3'd0, 32'h23, 32'h0, 0);
  endtask

  task automatic test_sw_and_errors();
    issue(3'd7, 32'h3FC, 32'hDEAD_BEEF, 0);
    issue(3'd2, 32'h3FC, 32'h0, 0);
    issue(3'd1, 32'h0D, 32'h0, 0);          // misaligned half
    issue(3'd7, 32'h400, 32'h1111_1111, 0); // out of range
    issue(3'd2, 32'h02, 32'h0, 0);
    issue(3'd6, 32'h01, 32'h0, 0);
    issue(3'd5, 32'h8000_0000, 32'h55, 0);
    issue(3'd2, 32'h0C, 32'h0, 0);
  endtask

  task automatic test_reset_mid_store();
    int wr, rv;
    @(negedge clk_i);
    req_valid_i = 1'b1; op_i = 3'd6; addr_i = 32'h0C; wdata_i = 32'h0000_CAFE;
    @(posedge clk_i);
    @(negedge clk_i);              // READ
    req_valid_i = 1'b0;
    @(negedge clk_i);              // WAIT
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    vectors++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || rdata_o !== 32'd0 || resp_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_store: ready=%b rv=%b rdata=%h err=%b, need 1/0/0/0",
               req_ready_o, resp_valid_o, rdata_o, resp_err_o);
    end
    wr = 0; rv = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (mem_MemWrite_o) wr++;
      if (resp_valid_o) rv++;
    end
    vectors++;
    if (wr !== 0 || rv !== 0) begin
      miscompares++;
      $display("FAIL reset_cancel: writes=%0d resp_valids=%0d, need 0/0", wr, rv);
    end
    issue(3'd2, 32'h0C, 32'h0, 0);   // word 3 must still read 8811AABB
  endtask

  task automatic test_held_request();
    issue(3'd2, 32'h0C, 32'h0, 1);
    issue(3'd5, 32'h21, 32'h0000_00C3, 1);
    issue(3'd7, 32'h40, 32'h0BAD_F00D, 1);
    issue(3'd4, 32'h3FE, 32'h0, 1);
    issue(3'd2, 32'h20, 32'h0, 1);
    issue(3'd2, 32'h40, 32'h0, 1);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  op;
    logic [31:0] addr;
    issue(3'd2, 32'h14, 32'h0, 0);
    issue(3'd7, 32'h14, 32'hA5A5_5A5A, 0);
    issue(3'd2, 32'h14, 32'h0, 0);
    for (int i = 0; i < 30; i++) begin
      op   = 3'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023);
      issue(op, addr, $urandom, 0);
    end
  endtask

  initial begin
    req_valid_i = 1'b0; op_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    tb_we = 1'b0; tb_wa = 8'd0; tb_wd = 32'd0;
    test_reset();
    preload();
    test_loads();
    test_subword_store();
    test_sw_and_errors();
    test_reset_mid_store();
    test_held_request();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
